cpu_boot_ctrl: RTL
==================

Name: cpu_boot_ctrl

Overview:
Boot and run controller for the FRANK6000 CPU core. It accepts a program as a byte stream over a valid/ready handshake and assembles 16-bit instruction words. It writes those words into instruction memory at sequential addresses, then sequences the core out of reset. Once the core is running, it gates the core clock-enable for free-run, halt and single-step operation.

Parameters:
ADDR_WIDTH, 8, instruction memory address width; maximum program length is 2**ADDR_WIDTH words.

Ports:
i_clk  input  1  system clock, rising edge
i_rst_n  input  1  asynchronous active-low reset
i_load  input  1  one-cycle pulse: begin a program load (accepted in any state)
i_byte  input  8  program stream byte
i_byte_valid  input  1  i_byte is valid this cycle
o_byte_ready  output  1  controller accepts i_byte this cycle
i_run  input  1  level: 1 = free-run, 0 = halt (only honoured when a program is loaded)
i_step  input  1  one-cycle pulse: execute one core cycle while halted
o_imem_addr  output  ADDR_WIDTH  instruction memory write address
o_imem_data  output  16  instruction memory write data
o_imem_we  output  1  instruction memory write enable
o_cpu_rst  output  1  active-high reset to the core
o_cpu_en  output  1  core clock-enable (gates PC/register writes)
o_loaded  output  1  a complete program is resident
o_state  output  3  current state encoding, for debug

Behaviour:
- Reset (async, i_rst_n=0) forces state IDLE. Output values in reset: o_byte_ready=0, o_imem_we=0, o_imem_addr=0, o_imem_data=0, o_cpu_rst=1, o_cpu_en=0, o_loaded=0. Internal word counter, address and high-byte register are cleared.
- Stream format:
  - First byte is the length L; word count N = L, with L=0 meaning 2**ADDR_WIDTH.
  - Then 2N bytes follow, high byte first per word.
- A byte transfer occurs on a rising edge where i_byte_valid & o_byte_ready are both 1. i_byte must be held while valid is high and ready is low.
- States:
  - IDLE: o_cpu_rst=1. On i_load go to LEN.
  - LEN: o_byte_ready=1. On transfer, latch N, clear the address, clear o_loaded, go to HI.
  - HI: o_byte_ready=1. On transfer, latch the high byte, go to LO.
  - LO: o_byte_ready=1. On transfer, go to WR.
  - WR: o_byte_ready=0. o_imem_we=1 for exactly one cycle, with o_imem_data={hi,lo} and o_imem_addr=current address.
    - If this was word N, go to RST and set o_loaded=1.
    - Otherwise increment the address and go to HI.
  - RST: hold o_cpu_rst=1 for exactly 2 cycles (release sequencing), then go to HALT.
  - HALT: o_cpu_rst=0, o_cpu_en=0. If i_run=1, go to RUN next cycle. Else if i_step=1, go to STEP.
  - STEP: o_cpu_en=1 for exactly one cycle, then go to HALT. Pulses arriving during STEP are ignored.
  - RUN: o_cpu_en=1 every cycle. On i_run=0, go to HALT; o_cpu_en drops in the cycle after i_run falls.
- Throughput: maximum one byte per cycle is not supported; a word costs 3 cycles minimum (HI, LO, WR).
- The address is only incremented in WR. Wrap at 2**ADDR_WIDTH cannot occur because the count bounds the address (word N lands at address N-1).
- i_load in any non-IDLE state:
  - Aborts the current activity and goes to LEN next cycle.
  - Asserts o_cpu_rst=1, o_cpu_en=0 and clears o_loaded.
  - A partial write in WR still completes in that same cycle: the WR write happens and the abort takes effect from the next cycle.
- Priority in HALT/RUN: i_load > i_run > i_step.
- i_run and i_step are ignored in IDLE, LEN, HI, LO, WR and RST.
- o_cpu_rst is 1 in every state except HALT, STEP and RUN.
- All outputs are registered or decoded from the registered state only. There is no combinational path from inputs to outputs except none: o_byte_ready depends on state only.

Decomposition:
- Shared package (cpu_boot_pkg): state encoding constants IDLE=0, LEN=1, HI=2, LO=3, WR=4, RST=5, HALT=6, RUN=7, plus STEP encoded as a sub-flag of HALT.
  - Alternatively, widen o_state to 4 bits if the package defines 9 states. Decision: o_state is 3 bits and STEP reports as HALT.
- One natural sub-module, cpu_boot_assembler: the HI/LO byte-to-word packer with its handshake. The FSM and run control stay in the top module.

Test Plan:
- Reset mid-load: assert i_rst_n=0 during LO -> all outputs return to reset values immediately (async), with no o_imem_we pulse.
- Load L=3, bytes 12 34 56 78 9A BC with valid held continuously:
  - Required writes: 0x1234@0, 0x5678@1, 0x9ABC@2, one o_imem_we cycle each.
  - Then o_loaded=1, o_cpu_rst stays high 2 cycles, then state HALT with o_cpu_en=0.
- Handshake stalls: same load with i_byte_valid toggling 1/0 each cycle -> identical memory contents, and no byte is duplicated or dropped.
- Halt and step: in HALT pulse i_step 3 times -> exactly 3 single-cycle o_cpu_en pulses. i_step held high for 4 cycles -> pulses on alternating cycles only (STEP->HALT->STEP).
- Run and stop: i_run=1 -> o_cpu_en=1 from the next cycle. i_run=0 -> o_cpu_en=0 one cycle later. i_run and i_step together in HALT -> RUN.
- Abort during RUN: i_load pulse -> next cycle state LEN, o_cpu_rst=1, o_cpu_en=0, o_loaded=0. L=0 followed by 512 bytes writes addresses 0..255 with no wrap write to 0.

Source files
------------

// File: rtl/cpu_boot_pkg.sv
// Shared types for the FRANK6000 boot/run controller: state encoding and data widths.
// STEP reuses the HALT debug code, with bit 3 as the step sub-flag.
package cpu_boot_pkg;

    localparam int BYTE_W = 8;
    localparam int WORD_W = 16;

    typedef enum logic [3:0] {
        ST_IDLE = 4'd0,
        ST_LEN  = 4'd1,
        ST_HI   = 4'd2,
        ST_LO   = 4'd3,
        ST_WR   = 4'd4,
        ST_RST  = 4'd5,
        ST_HALT = 4'd6,
        ST_RUN  = 4'd7,
        ST_STEP = 4'b1110
    } state_e;

    function automatic logic core_released(input state_e s);
        return (s == ST_HALT) || (s == ST_STEP) || (s == ST_RUN);
    endfunction

endpackage

// File: rtl/cpu_boot_assembler.sv
// Byte-to-word packer: owns the byte handshake and the high/low byte registers.
// The controlling FSM tells it which byte of the stream it is currently accepting.
module cpu_boot_assembler
    import cpu_boot_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              accept,
    input  logic              take_hi,
    input  logic              take_lo,
    input  logic [BYTE_W-1:0] data_byte,
    input  logic              byte_valid,
    output logic              byte_ready,
    output logic              xfer,
    output logic [WORD_W-1:0] word
);

    logic [BYTE_W-1:0] hi_q;
    logic [BYTE_W-1:0] lo_q;

    assign byte_ready = accept;
    assign xfer       = accept & byte_valid;
    assign word       = {hi_q, lo_q};

    // NOTE: the byte registers are reset (unlike a RAM) because the write-data
    // output they drive must read as zero while the block is held in reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hi_q <= '0;
            lo_q <= '0;
        end else begin
            if (take_hi && byte_valid) hi_q <= data_byte;
            if (take_lo && byte_valid) lo_q <= data_byte;
        end
    end

endmodule

// File: rtl/cpu_boot_ctrl.sv
// Boot and run controller: loads a length-prefixed byte stream into instruction
// memory, releases the core from reset, then gates its clock-enable (run/halt/step).
module cpu_boot_ctrl
    import cpu_boot_pkg::*;
#(
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_load,
    input  logic [BYTE_W-1:0]     i_byte,
    input  logic                  i_byte_valid,
    output logic                  o_byte_ready,
    input  logic                  i_run,
    input  logic                  i_step,
    output logic [ADDR_WIDTH-1:0] o_imem_addr,
    output logic [WORD_W-1:0]     o_imem_data,
    output logic                  o_imem_we,
    output logic                  o_cpu_rst,
    output logic                  o_cpu_en,
    output logic                  o_loaded,
    output logic [2:0]            o_state
);

    state_e                state;
    logic [ADDR_WIDTH-1:0] addr;
    logic [ADDR_WIDTH-1:0] last_addr;
    logic [ADDR_WIDTH-1:0] len_last;
    logic                  loaded;
    logic                  rst_cnt;
    logic                  accept;
    logic                  xfer;
    logic [WORD_W-1:0]     word;

    // A length byte of zero stands for a full 2**ADDR_WIDTH-word image.
    assign len_last = (i_byte == '0) ? '1 : ADDR_WIDTH'(i_byte - BYTE_W'(1));
    assign accept   = (state == ST_LEN) || (state == ST_HI) || (state == ST_LO);

    cpu_boot_assembler u_assembler (
        .clk        (i_clk),
        .rst_n      (i_rst_n),
        .accept     (accept),
        .take_hi    (state == ST_HI),
        .take_lo    (state == ST_LO),
        .data_byte  (i_byte),
        .byte_valid (i_byte_valid),
        .byte_ready (o_byte_ready),
        .xfer       (xfer),
        .word       (word)
    );

    // NOTE: every register here is assigned with <= so all of them update from
    // the same pre-edge values, regardless of statement order.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state     <= ST_IDLE;
            addr      <= '0;
            last_addr <= '0;
            loaded    <= 1'b0;
            rst_cnt   <= 1'b0;
        end else if (i_load) begin
            // Abort from anywhere; a write showing in WR this cycle still lands.
            state  <= ST_LEN;
            loaded <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: ;
                ST_LEN: if (xfer) begin
                    last_addr <= len_last;
                    addr      <= '0;
                    loaded    <= 1'b0;
                    state     <= ST_HI;
                end
                ST_HI: if (xfer) state <= ST_LO;
                ST_LO: if (xfer) state <= ST_WR;
                ST_WR: begin
                    if (addr == last_addr) begin
                        loaded  <= 1'b1;
                        rst_cnt <= 1'b0;
                        state   <= ST_RST;
                    end else begin
                        addr  <= addr + ADDR_WIDTH'(1);
                        state <= ST_HI;
                    end
                end
                ST_RST: begin
                    if (rst_cnt) state <= ST_HALT;
                    rst_cnt <= 1'b1;
                end
                ST_HALT: begin
                    if (i_run)       state <= ST_RUN;
                    else if (i_step) state <= ST_STEP;
                end
                ST_STEP: state <= ST_HALT;
                ST_RUN:  if (!i_run) state <= ST_HALT;
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign o_imem_addr = addr;
    assign o_imem_data = word;
    assign o_imem_we   = (state == ST_WR);
    assign o_cpu_rst   = !core_released(state);
    assign o_cpu_en    = (state == ST_RUN) || (state == ST_STEP);
    assign o_loaded    = loaded;
    assign o_state     = state[2:0];

endmodule
